// File: rtl/dac_spi_writer_pkg.sv
// Shared constants, FSM encoding and sizing helper for the DAC SPI writer.
package dac_spi_writer_pkg;

  localparam int          FRAME_W          = 32;
  localparam int          DAC_FIELD_W      = 12;
  localparam logic [3:0]  CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0]  ADDR_ALL         = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Bits needed to hold values 0..v-1.
  function automatic int clogb2(input int v);
    int r;
    int x;
    r = 0;
    for (x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/dac_spi_writer_if.sv
// Generator/DAC side signals of the SPI writer, grouped as one bus.
interface dac_spi_writer_if #(
  parameter int SIZE = 12
);
  logic            start;
  logic [SIZE-1:0] data;
  logic            next;
  logic            done;
  logic            busy;
  logic            spi_sck;
  logic            spi_mosi;
  logic            dac_cs_n;
  logic            dac_clr_n;

  // The writer itself.
  modport slave (
    input  start, data,
    output next, done, busy, spi_sck, spi_mosi, dac_cs_n, dac_clr_n
  );

  // Whoever paces and feeds the writer.
  modport master (
    output start, data,
    input  next, done, busy, spi_sck, spi_mosi, dac_cs_n, dac_clr_n
  );
endinterface

// File: rtl/dac_spi_writer_sck_tick_gen.sv
// Divider producing a one-cycle enable every CLK_DIV clocks while enabled.
module sck_tick_gen
  import dac_spi_writer_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? clogb2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == DIV_W'(CLK_DIV - 1));

  // Next count: clear wins, otherwise count up and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_spi_writer.sv
// Serialises one sample per start tick as a 32-bit LTC2624-style write frame.
module dac_spi_writer
  import dac_spi_writer_pkg::*;
#(
  parameter int         SIZE    = 12,
  parameter int         CLK_DIV = 2,
  parameter logic [3:0] CMD     = CMD_WRITE_UPDATE,
  parameter logic [3:0] ADDR    = ADDR_ALL
) (
  input  logic            clk,
  input  logic            rst,
  dac_spi_writer_if.slave bus
);

  localparam int PAD = DAC_FIELD_W - SIZE;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [4:0]         bit_q, bit_d;
  logic               sck_q, sck_d;
  logic               cs_n_q, cs_n_d;
  logic               done_q, done_d;
  logic               next_q, next_d;
  logic               busy_q, busy_d;
  logic               clr_n_q;
  logic               tick, tick_en, tick_clr;
  logic [DAC_FIELD_W-1:0] field;
  logic [FRAME_W-1:0]     frame;

  // Sample is left-justified into the DAC field.
  assign field = DAC_FIELD_W'(bus.data) << PAD;
  assign frame = {8'h00, CMD, ADDR, field, 4'h0};

  assign tick_en = (state_q != S_IDLE);

  sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  // Next-state and output logic; MOSI is the shift register MSB.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    next_d   = 1'b0;
    tick_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        tick_clr = 1'b1;
        if (bus.start) begin
          sr_d    = frame;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          sck_d = ~sck_q;
          if (sck_q) begin
            if (bit_q == 5'd31) begin
              sr_d     = '0;
              cs_n_d   = 1'b1;
              done_d   = 1'b1;
              next_d   = 1'b1;
              tick_clr = 1'b1;
              state_d  = S_GAP;
            end else begin
              sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
              bit_d = bit_q + 5'd1;
            end
          end
        end
      end
      S_GAP: begin
        // Minimum CS high time before the next frame can be accepted.
        if (tick) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops CS and SCK immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      next_q  <= 1'b0;
      busy_q  <= 1'b0;
      clr_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      next_q  <= next_d;
      busy_q  <= busy_d;
      clr_n_q <= 1'b1;
    end
  end

  assign bus.spi_sck   = sck_q;
  assign bus.spi_mosi  = sr_q[FRAME_W-1];
  assign bus.dac_cs_n  = cs_n_q;
  assign bus.dac_clr_n = clr_n_q;
  assign bus.done      = done_q;
  assign bus.next      = next_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench: reset, single frame, back-to-back, ignored start, mid-frame reset, SIZE=8.
module tb_dac_spi_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dac_spi_writer_if #(.SIZE(12)) bus  ();
  dac_spi_writer_if #(.SIZE(8))  bus8 ();

  dac_spi_writer #(.SIZE(12), .CLK_DIV(2)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  dac_spi_writer #(.SIZE(8),  .CLK_DIV(1)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int vecs = 0;
  int errs = 0;

  // Monitor for the 12-bit instance, sampled on the inactive edge.
  int          rises = 0, nexts = 0, dn_pairs = 0;
  int          lo_run = 0, hi_run = 0, last_lo = 0, last_hi = 0;
  logic [31:0] cap = '0;
  logic        sck_p = 1'b0;
  always @(negedge clk) begin
    if (bus.spi_sck && !sck_p) begin
      rises <= rises + 1;
      cap   <= {cap[30:0], bus.spi_mosi};
    end
    sck_p <= bus.spi_sck;
    if (bus.next)             nexts    <= nexts + 1;
    if (bus.next && bus.done) dn_pairs <= dn_pairs + 1;
    if (!bus.dac_cs_n) begin
      lo_run <= lo_run + 1;
      if (hi_run != 0) last_hi <= hi_run;
      hi_run <= 0;
    end else begin
      hi_run <= hi_run + 1;
      if (lo_run != 0) last_lo <= lo_run;
      lo_run <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (bus.done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!bus.busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  initial begin
    logic [31:0] exp_abc, exp_a5, cap8;
    bit ok;
    int r0, n0, d0, cnt, busy_low, lo8, nframes;
    logic sp8, dn8;

    exp_abc = {8'h00, 4'b0011, 4'b1111, 12'hABC, 4'h0};
    exp_a5  = {8'h00, 4'b0011, 4'b1111, 12'hA50, 4'h0};

    bus.start = 1'b0;  bus.data = 12'hABC;
    bus8.start = 1'b0; bus8.data = 8'hA5;

    // 1. reset state and clear release
    #1 rst = 1'b1;
    tick();
    chk("rst_cs_n",  32'(bus.dac_cs_n),  32'd1);
    chk("rst_sck",   32'(bus.spi_sck),   32'd0);
    chk("rst_mosi",  32'(bus.spi_mosi),  32'd0);
    chk("rst_clr_n", 32'(bus.dac_clr_n), 32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_next",  32'(bus.next),      32'd0);
    rst = 1'b0;
    #1 chk("clr_n_pre", 32'(bus.dac_clr_n), 32'd0);
    tick();
    chk("clr_n_post", 32'(bus.dac_clr_n), 32'd1);
    tick();

    // 2. single frame, CLK_DIV=2, data=ABC
    r0 = rises; n0 = nexts; d0 = dn_pairs;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t2_cs_low", 32'(bus.dac_cs_n), 32'd0);
    chk("t2_mosi0",  32'(bus.spi_mosi), 32'd0);
    tick();
    chk("t2_busy",   32'(bus.busy), 32'd1);
    wait_done(300, ok);
    chk("t2_done_seen", 32'(ok), 32'd1);
    chk("t2_next_with_done", 32'(bus.next), 32'd1);
    tick();
    chk("t2_done_1cyc", 32'(bus.done), 32'd0);
    chk("t2_next_1cyc", 32'(bus.next), 32'd0);
    wait_idle(20, ok);
    chk("t2_idle", 32'(ok), 32'd1);
    tick();
    chk("t2_rises",    32'(rises - r0),    32'd32);
    chk("t2_frame",    cap,                exp_abc);
    chk("t2_cs_len",   32'(last_lo),       32'd128);
    chk("t2_nexts",    32'(nexts - n0),    32'd1);
    chk("t2_dn_pairs", 32'(dn_pairs - d0), 32'd1);

    // 3. start held high: back-to-back frames
    n0 = nexts; r0 = rises;
    bus.start = 1'b1;
    nframes = 0;
    for (int f = 0; f < 3; f++) begin
      wait_done(300, ok);
      if (ok) nframes++;
    end
    bus.start = 1'b0;
    chk("t3_frames_seen", 32'(nframes), 32'd3);
    wait_idle(20, ok);
    chk("t3_idle", 32'(ok), 32'd1);
    tick();
    chk("t3_nexts",  32'(nexts - n0), 32'd3);
    chk("t3_rises",  32'(rises - r0), 32'd96);
    chk("t3_cs_gap", 32'(last_hi),    32'd3);
    chk("t3_frame",  cap,             exp_abc);

    // 4. extra start and data change mid-frame are ignored
    n0 = nexts; r0 = rises;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_low = 0;
    for (int i = 0; i < 10; i++) tick();
    bus.start = 1'b1; bus.data = 12'h123;
    tick();
    bus.start = 1'b0;
    cnt = 0; ok = 1'b0;
    while (cnt < 300 && !ok) begin
      if (!bus.busy) busy_low++;
      tick();
      cnt++;
      if (bus.done) ok = 1'b1;
    end
    chk("t4_done_seen", 32'(ok), 32'd1);
    chk("t4_busy_held", 32'(busy_low), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("t4_no_refire", 32'(bus.dac_cs_n), 32'd1);
    chk("t4_nexts",     32'(nexts - n0),   32'd1);
    chk("t4_rises",     32'(rises - r0),   32'd32);
    chk("t4_frame",     cap,               exp_abc);
    bus.data = 12'hABC;

    // 5. reset mid-frame, then a clean frame
    n0 = nexts; r0 = rises;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cnt = 0;
    while (cnt < 300 && (rises - r0) < 16) begin tick(); cnt++; end
    chk("t5_reached_bit15", 32'(rises - r0), 32'd16);
    chk("t5_cs_low_before", 32'(bus.dac_cs_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_cs_async",  32'(bus.dac_cs_n), 32'd1);
    chk("t5_sck_async", 32'(bus.spi_sck),  32'd0);
    chk("t5_busy_rst",  32'(bus.busy),     32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("t5_no_next", 32'(nexts - n0), 32'd0);
    r0 = rises; n0 = nexts;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(300, ok);
    chk("t5_done_seen", 32'(ok), 32'd1);
    wait_idle(20, ok);
    tick();
    chk("t5_rises", 32'(rises - r0), 32'd32);
    chk("t5_frame", cap,             exp_abc);
    chk("t5_nexts", 32'(nexts - n0), 32'd1);

    // 6. SIZE=8, CLK_DIV=1, data=A5
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lo8 = 0; sp8 = 1'b0; cap8 = '0; dn8 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus8.dac_cs_n) lo8++;
      if (bus8.spi_sck && !sp8) cap8 = {cap8[30:0], bus8.spi_mosi};
      sp8 = bus8.spi_sck;
      if (bus8.done) begin dn8 = 1'b1; break; end
      tick();
    end
    chk("t6_done_seen", 32'(dn8),       32'd1);
    chk("t6_next",      32'(bus8.next), 32'd1);
    chk("t6_frame",     cap8,           exp_a5);
    chk("t6_cs_len",    32'(lo8),       32'd64);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
